// File: rtl/piece_move_scheduler.sv
// piece_move_scheduler
//
// Sequences every movement of the active tetromino. Player and gravity
// requests are latched into a pending set. They are served one at a time in
// round-robin order by enabling the matching collision checker. A move is
// committed only when its checker reports no collision. A colliding gravity
// step raises lock_piece instead. The board RAM read port is shared between
// the running checker and the render engine. Render wins whenever the
// scheduler is idle.
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   new_piece              load spawn position / rotation 0, drop all requests
//   req_rotate/left/right/down  one-cycle request pulses
//   chk_enable[3:0]        one-hot checker enable (0 rotate, 1 left, 2 right, 3 down)
//   chk_complete[3:0]      per-checker completion pulse
//   chk_collides[3:0]      per-checker collision result
//   chk_addr0..3[7:0]      per-checker RAM address
//   render_req, render_addr  render engine port request / address
//   render_gnt             render owns the RAM port this cycle (combinational)
//   ram_addr[7:0]          board RAM read address (combinational)
//   X_anchor, Y_anchor, curr_rotation  active piece position and rotation
//   lock_piece             one-cycle pulse: gravity step collided
//   busy                   high while a move is being checked or committed
module piece_move_scheduler #(
    parameter logic [4:0] SPAWN_X = 5'd4,
    parameter logic [5:0] SPAWN_Y = 6'd0,
    parameter logic [2:0] TIMEOUT = 3'd7
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       new_piece,
    input  logic       req_rotate,
    input  logic       req_left,
    input  logic       req_right,
    input  logic       req_down,
    output logic [3:0] chk_enable,
    input  logic [3:0] chk_complete,
    input  logic [3:0] chk_collides,
    input  logic [7:0] chk_addr0,
    input  logic [7:0] chk_addr1,
    input  logic [7:0] chk_addr2,
    input  logic [7:0] chk_addr3,
    input  logic       render_req,
    input  logic [7:0] render_addr,
    output logic       render_gnt,
    output logic [7:0] ram_addr,
    output logic [4:0] X_anchor,
    output logic [5:0] Y_anchor,
    output logic [1:0] curr_rotation,
    output logic       lock_piece,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [1:0] MV_ROTATE = 2'd0;
    localparam logic [1:0] MV_LEFT   = 2'd1;
    localparam logic [1:0] MV_RIGHT  = 2'd2;
    localparam logic [1:0] MV_DOWN   = 2'd3;

    state_t     state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic [1:0] rr_q, rr_d;
    logic [1:0] sel_q, sel_d;
    logic       coll_q, coll_d;
    logic [2:0] tmo_q, tmo_d;
    logic [4:0] x_q, x_d;
    logic [5:0] y_q, y_d;
    logic [1:0] rot_q, rot_d;
    logic [3:0] chk_enable_q, chk_enable_d;
    logic       lock_q, lock_d;
    logic       busy_q, busy_d;

    logic [3:0] set_bits;
    logic [3:0] clr_bits;
    logic [1:0] pick;
    logic [7:0] chk_addr_sel;

    // First pending bit at or after ptr, wrapping 3->0. Scanning from the
    // farthest offset down lets the nearest candidate overwrite the result.
    function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (pend[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    assign set_bits = {req_down, req_right, req_left, req_rotate};
    assign pick     = rr_pick(pending_q, rr_q);

    always_comb begin
        case (sel_q)
            MV_ROTATE: chk_addr_sel = chk_addr0;
            MV_LEFT:   chk_addr_sel = chk_addr1;
            MV_RIGHT:  chk_addr_sel = chk_addr2;
            default:   chk_addr_sel = chk_addr3;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        sel_d    = sel_q;
        coll_d   = coll_q;
        tmo_d    = tmo_q;
        x_d      = x_q;
        y_d      = y_q;
        rot_d    = rot_q;
        lock_d   = 1'b0;
        clr_bits = 4'b0000;

        case (state_q)
            ST_IDLE: begin
                if (!render_req && (pending_q != 4'b0000)) begin
                    sel_d   = pick;
                    rr_d    = pick + 2'd1;
                    tmo_d   = 3'd0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (chk_complete[sel_q]) begin
                    coll_d  = chk_collides[sel_q];
                    state_d = ST_COMMIT;
                end else if ((tmo_q + 3'd1) == TIMEOUT) begin
                    // A checker that never answers is treated as a collision.
                    coll_d  = 1'b1;
                    state_d = ST_COMMIT;
                end else begin
                    tmo_d = tmo_q + 3'd1;
                end
            end
            ST_COMMIT: begin
                state_d         = ST_IDLE;
                clr_bits[sel_q] = 1'b1;
                if (!coll_q) begin
                    case (sel_q)
                        MV_ROTATE: rot_d = rot_q + 2'd1;
                        MV_LEFT:   x_d   = x_q - 5'd1;
                        MV_RIGHT:  x_d   = x_q + 5'd1;
                        default:   y_d   = y_q + 6'd1;
                    endcase
                end else if (sel_q == MV_DOWN) begin
                    // The piece is landing: anything still queued is stale.
                    lock_d   = 1'b1;
                    clr_bits = 4'b1111;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A request arriving on the clearing edge survives.
        pending_d = (pending_q & ~clr_bits) | set_bits;

        if (new_piece) begin
            state_d   = ST_IDLE;
            pending_d = 4'b0000;
            x_d       = SPAWN_X;
            y_d       = SPAWN_Y;
            rot_d     = 2'd0;
            lock_d    = 1'b0;
        end

        chk_enable_d = (state_d == ST_CHECK) ? (4'b0001 << sel_d) : 4'b0000;
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            pending_q    <= 4'b0000;
            rr_q         <= 2'd0;
            sel_q        <= 2'd0;
            coll_q       <= 1'b0;
            tmo_q        <= 3'd0;
            x_q          <= SPAWN_X;
            y_q          <= SPAWN_Y;
            rot_q        <= 2'd0;
            chk_enable_q <= 4'b0000;
            lock_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            rr_q         <= rr_d;
            sel_q        <= sel_d;
            coll_q       <= coll_d;
            tmo_q        <= tmo_d;
            x_q          <= x_d;
            y_q          <= y_d;
            rot_q        <= rot_d;
            chk_enable_q <= chk_enable_d;
            lock_q       <= lock_d;
            busy_q       <= busy_d;
        end
    end

    // RAM port arbitration: render only while idle, the active checker in CHECK.
    always_comb begin
        render_gnt = 1'b0;
        ram_addr   = 8'd0;
        case (state_q)
            ST_IDLE: begin
                if (render_req) begin
                    render_gnt = 1'b1;
                    ram_addr   = render_addr;
                end
            end
            ST_CHECK: ram_addr = chk_addr_sel;
            default: ;
        endcase
    end

    assign chk_enable    = chk_enable_q;
    assign X_anchor      = x_q;
    assign Y_anchor      = y_q;
    assign curr_rotation = rot_q;
    assign lock_piece    = lock_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_piece_move_scheduler.sv
module tb_piece_move_scheduler;

    logic       clk;
    logic       resetn;
    logic       new_piece;
    logic       req_rotate, req_left, req_right, req_down;
    logic [3:0] chk_enable;
    logic [3:0] chk_complete;
    logic [3:0] chk_collides;
    logic [7:0] chk_addr0, chk_addr1, chk_addr2, chk_addr3;
    logic       render_req;
    logic [7:0] render_addr;
    logic       render_gnt;
    logic [7:0] ram_addr;
    logic [4:0] X_anchor;
    logic [5:0] Y_anchor;
    logic [1:0] curr_rotation;
    logic       lock_piece;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // checker model configuration
    bit         auto_en  = 1'b1;
    int         lat_cfg  = 4;
    logic [3:0] coll_cfg = 4'b0000;

    // monitor results
    logic [3:0] en_q[$];
    int         n_pulse = 0;
    int         n_lock  = 0;

    piece_move_scheduler dut (
        .clk          (clk),
        .resetn       (resetn),
        .new_piece    (new_piece),
        .req_rotate   (req_rotate),
        .req_left     (req_left),
        .req_right    (req_right),
        .req_down     (req_down),
        .chk_enable   (chk_enable),
        .chk_complete (chk_complete),
        .chk_collides (chk_collides),
        .chk_addr0    (chk_addr0),
        .chk_addr1    (chk_addr1),
        .chk_addr2    (chk_addr2),
        .chk_addr3    (chk_addr3),
        .render_req   (render_req),
        .render_addr  (render_addr),
        .render_gnt   (render_gnt),
        .ram_addr     (ram_addr),
        .X_anchor     (X_anchor),
        .Y_anchor     (Y_anchor),
        .curr_rotation(curr_rotation),
        .lock_piece   (lock_piece),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Collision checker model: answers after lat_cfg enabled cycles.
    initial begin : checker_model
        int cnt;
        cnt          = 0;
        chk_complete = 4'b0000;
        chk_collides = 4'b0000;
        forever begin
            @(negedge clk);
            chk_complete = 4'b0000;
            chk_collides = 4'b0000;
            if (auto_en && chk_enable != 4'b0000) begin
                cnt++;
                if (cnt == lat_cfg) begin
                    chk_complete = chk_enable;
                    chk_collides = chk_enable & coll_cfg;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Records every checker launch and every lock pulse.
    initial begin : monitor
        logic [3:0] prev;
        prev = 4'b0000;
        forever begin
            @(negedge clk);
            if (chk_enable != 4'b0000 && prev == 4'b0000) begin
                en_q.push_back(chk_enable);
                n_pulse++;
            end
            if (lock_piece) n_lock++;
            prev = chk_enable;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic pulse(input logic [3:0] r);
        @(negedge clk);
        {req_down, req_right, req_left, req_rotate} = r;
        @(negedge clk);
        {req_down, req_right, req_left, req_rotate} = 4'b0000;
    endtask

    task automatic pulse_new_piece();
        new_piece = 1'b1;
        @(negedge clk);
        new_piece = 1'b0;
    endtask

    // Waits until the scheduler has stayed quiet for three cycles.
    task automatic wait_idle(input string name);
        int quiet;
        int t;
        quiet = 0;
        t     = 0;
        while (quiet < 3 && t < 400) begin
            @(negedge clk);
            t++;
            if (!busy && chk_enable == 4'b0000) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scheduler still busy after %0d cycles", name, t);
        end
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] coll;
        int         lat;
        logic [4:0] x;
        logic [5:0] y;
        logic [1:0] rot;
        int         locks;
        int         pulses;
    } vec_t;

    vec_t vecs[8];

    initial begin : main
        int         lock0, pulse0, cnt;
        logic [3:0] req, coll;
        int         m_rr, m_x, m_y, m_rot, m_locks, s;
        logic [3:0] pend;
        int         exp_order[$];

        //          req      coll     lat  x      y      rot   locks pulses
        vecs[0] = '{4'b0010, 4'b0000, 4, 5'd3, 6'd0, 2'd0, 0, 1};
        vecs[1] = '{4'b1000, 4'b1000, 3, 5'd4, 6'd0, 2'd0, 1, 1};
        vecs[2] = '{4'b1111, 4'b0000, 2, 5'd4, 6'd1, 2'd1, 0, 4};
        vecs[3] = '{4'b0100, 4'b0000, 1, 5'd5, 6'd0, 2'd0, 0, 1};
        vecs[4] = '{4'b0001, 4'b0001, 2, 5'd4, 6'd0, 2'd0, 0, 1};
        vecs[5] = '{4'b1011, 4'b1000, 3, 5'd3, 6'd0, 2'd1, 1, 3};
        vecs[6] = '{4'b1110, 4'b0010, 2, 5'd5, 6'd1, 2'd0, 0, 3};
        vecs[7] = '{4'b1001, 4'b0000, 5, 5'd4, 6'd1, 2'd1, 0, 2};

        resetn      = 1'b0;
        new_piece   = 1'b0;
        {req_down, req_right, req_left, req_rotate} = 4'b0000;
        render_req  = 1'b0;
        render_addr = 8'h00;
        chk_addr0   = 8'h3C;
        chk_addr1   = 8'h4D;
        chk_addr2   = 8'h5E;
        chk_addr3   = 8'h6F;

        // Reset state
        do_reset();
        check("rst_x", X_anchor, 4);
        check("rst_y", Y_anchor, 0);
        check("rst_rot", curr_rotation, 0);
        check("rst_chk_enable", chk_enable, 0);
        check("rst_lock", lock_piece, 0);
        check("rst_busy", busy, 0);
        check("rst_render_gnt", render_gnt, 0);
        check("rst_ram_addr", ram_addr, 0);

        // Basic move with cycle detail
        lat_cfg  = 4;
        coll_cfg = 4'b0000;
        pulse0   = n_pulse;
        pulse(4'b0010);
        @(negedge clk);
        check("basic_enable_after_one_edge", chk_enable, 4'b0010);
        check("basic_ram_addr_checker", ram_addr, 8'h4D);
        cnt = 0;
        while (chk_enable != 4'b0000 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("basic_enable_cycles", cnt, 4);
        check("basic_busy_in_commit", busy, 1);
        @(negedge clk);
        check("basic_x_after_commit", X_anchor, 3);
        check("basic_busy_after_commit", busy, 0);
        check("basic_single_pulse", n_pulse - pulse0, 1);

        // Table-driven vectors, each from a fresh reset
        for (int i = 0; i < 8; i++) begin
            do_reset();
            lat_cfg  = vecs[i].lat;
            coll_cfg = vecs[i].coll;
            lock0    = n_lock;
            pulse0   = n_pulse;
            pulse(vecs[i].req);
            wait_idle($sformatf("vec%0d_idle", i));
            check($sformatf("vec%0d_x", i), X_anchor, vecs[i].x);
            check($sformatf("vec%0d_y", i), Y_anchor, vecs[i].y);
            check($sformatf("vec%0d_rot", i), curr_rotation, vecs[i].rot);
            check($sformatf("vec%0d_locks", i), n_lock - lock0, vecs[i].locks);
            check($sformatf("vec%0d_pulses", i), n_pulse - pulse0, vecs[i].pulses);
        end

        // Render priority
        do_reset();
        lat_cfg     = 2;
        coll_cfg    = 4'b0000;
        @(negedge clk);
        render_req  = 1'b1;
        render_addr = 8'hA5;
        pulse(4'b0001);
        repeat (3) @(negedge clk);
        check("render_gnt_high", render_gnt, 1);
        check("render_ram_addr", ram_addr, 8'hA5);
        check("render_stalls_check", chk_enable, 0);
        render_req = 1'b0;
        @(negedge clk);
        check("render_check_starts", chk_enable, 4'b0001);
        check("render_gnt_released", render_gnt, 0);
        check("render_ram_addr_checker", ram_addr, 8'h3C);
        wait_idle("render_idle");
        check("render_rot_committed", curr_rotation, 1);

        // Timeout: checker never answers
        do_reset();
        auto_en = 1'b0;
        pulse(4'b0010);
        cnt = 0;
        @(negedge clk);
        while (chk_enable != 4'b0000 && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_check_cycles", cnt, 7);
        check("timeout_enable_low", chk_enable, 0);
        wait_idle("timeout_idle");
        check("timeout_x_unchanged", X_anchor, 4);
        auto_en = 1'b1;

        // new_piece aborts a running check
        do_reset();
        lat_cfg  = 2;
        coll_cfg = 4'b0000;
        pulse(4'b0100);
        wait_idle("abort_setup_idle");
        check("abort_setup_x", X_anchor, 5);
        auto_en = 1'b0;
        pulse(4'b1000);
        @(negedge clk);
        check("abort_in_check", chk_enable, 4'b1000);
        lock0 = n_lock;
        pulse_new_piece();
        check("abort_enable_dropped", chk_enable, 0);
        check("abort_busy", busy, 0);
        check("abort_x_spawn", X_anchor, 4);
        check("abort_y_spawn", Y_anchor, 0);
        check("abort_rot_spawn", curr_rotation, 0);
        repeat (12) @(negedge clk);
        check("abort_no_restart", chk_enable, 0);
        check("abort_no_lock", n_lock - lock0, 0);
        check("abort_y_stays", Y_anchor, 0);
        auto_en = 1'b1;

        // Asynchronous reset mid-check
        pulse(4'b0100);
        wait_idle("areset_setup_idle");
        check("areset_setup_x", X_anchor, 5);
        auto_en = 1'b0;
        pulse(4'b0001);
        @(negedge clk);
        check("areset_busy_before", busy, 1);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("areset_x", X_anchor, 4);
        check("areset_y", Y_anchor, 0);
        check("areset_rot", curr_rotation, 0);
        check("areset_chk_enable", chk_enable, 0);
        check("areset_busy", busy, 0);
        check("areset_lock", lock_piece, 0);
        check("areset_render_gnt", render_gnt, 0);
        check("areset_ram_addr", ram_addr, 0);
        @(negedge clk);
        resetn  = 1'b1;
        auto_en = 1'b1;

        // Randomized transactions against a transaction-level model
        do_reset();
        m_rr  = 0;
        m_x   = 4;
        m_y   = 0;
        m_rot = 0;
        for (int t = 0; t < 40; t++) begin
            req      = 4'($urandom_range(1, 15));
            coll     = 4'($urandom_range(0, 15));
            lat_cfg  = $urandom_range(1, 5);
            coll_cfg = coll;

            exp_order.delete();
            m_locks = 0;
            pend    = req;
            while (pend != 4'b0000) begin
                s = m_rr;
                for (int k = 0; k < 4; k++) begin
                    if (pend[(m_rr + k) % 4]) begin
                        s = (m_rr + k) % 4;
                        break;
                    end
                end
                exp_order.push_back(s);
                m_rr    = (s + 1) % 4;
                pend[s] = 1'b0;
                if (!coll[s]) begin
                    case (s)
                        0: m_rot = (m_rot + 1) % 4;
                        1: m_x = (m_x + 31) % 32;
                        2: m_x = (m_x + 1) % 32;
                        default: m_y = (m_y + 1) % 64;
                    endcase
                end else if (s == 3) begin
                    m_locks++;
                    pend = 4'b0000;
                end
            end

            en_q.delete();
            lock0 = n_lock;
            pulse(req);
            wait_idle($sformatf("rand%0d_idle", t));
            check($sformatf("rand%0d_moves", t), en_q.size(), exp_order.size());
            for (int i = 0; i < exp_order.size(); i++) begin
                if (i < en_q.size())
                    check($sformatf("rand%0d_order%0d", t, i), en_q[i], 4'b0001 << exp_order[i]);
            end
            check($sformatf("rand%0d_x", t), X_anchor, m_x);
            check($sformatf("rand%0d_y", t), Y_anchor, m_y);
            check($sformatf("rand%0d_rot", t), curr_rotation, m_rot);
            check($sformatf("rand%0d_locks", t), n_lock - lock0, m_locks);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/piece_move_scheduler.md
# piece_move_scheduler

Sequences all movement of the active tetromino. Latches player and gravity requests (rotate, left, right, down), launches the matching collision checker, and shares the board RAM read port between the running checker and the render engine. Owns the active piece's anchor and rotation registers, commits a move only when its checker reports no collision, and raises `lock_piece` when a gravity step collides.

## Interface
- `SPAWN_X`, default 5'd4: X anchor loaded on reset and on `new_piece`.
- `SPAWN_Y`, default 6'd0: Y anchor loaded on reset and on `new_piece`.
- `TIMEOUT`, default 3'd7: cycles in CHECK without `chk_complete` before the check is forced to "collides".
- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `new_piece`  in  1  one-cycle pulse: load spawn position and rotation 0, clear all pending requests.
- `req_rotate`, `req_left`, `req_right`, `req_down`  in  1 each  one-cycle request pulses; `req_down` is the gravity tick or soft drop.
- `chk_enable`  out  4  one-hot checker enable; bit 0 rotate, 1 left, 2 right, 3 down.
- `chk_complete`  in  4  per-checker completion pulse.
- `chk_collides`  in  4  per-checker collision result; valid when the matching `chk_complete` bit is high.
- `chk_addr0` to `chk_addr3`  in  8 each  per-checker RAM address.
- `render_req`  in  1  render engine requests the RAM port.
- `render_addr`  in  8  render engine address.
- `render_gnt`  out  1  render owns the port this cycle.
- `ram_addr`  out  8  board RAM read address (RAM data goes directly to all readers).
- `X_anchor`  out  5  active piece X.
- `Y_anchor`  out  6  active piece Y.
- `curr_rotation`  out  2  active piece rotation.
- `lock_piece`  out  1  one-cycle pulse: the down move collided and the piece must be locked.
- `busy`  out  1  high in CHECK and COMMIT.

## Operation
- **Pending requests.** `pending[3:0]` uses the same bit order as `chk_enable`.
  - A request pulse sets its bit.
  - A bit clears when its COMMIT completes.
  - If a set and a clear hit the same bit on the same edge, the set wins.
  - `new_piece` clears all bits and overrides any set on the same edge.
- **Selection.** Round-robin pointer `rr[1:0]`, reset value 0. In IDLE, `sel` is the first pending bit at or after `rr`, wrapping 3→0. On entering CHECK, `rr` becomes `sel+1` mod 4.
- **FSM states: IDLE, CHECK, COMMIT.**
  - IDLE:
    - If `render_req`: `render_gnt`=1, `ram_addr`=`render_addr`, stay in IDLE. Render has priority over starting a check.
    - Else if `pending` is nonzero: latch `sel`, clear the timeout counter, go to CHECK.
    - Else: `ram_addr`=0.
  - CHECK:
    - Signals: `chk_enable`=1<<`sel`, `ram_addr`=`chk_addr[sel]`, `render_gnt`=0.
    - On `chk_complete[sel]`: latch `coll`=`chk_collides[sel]`, go to COMMIT.
    - On timeout (counter reaches `TIMEOUT` without completion): `coll`=1, go to COMMIT.
  - COMMIT:
    - `chk_enable`=0. This guarantees at least one low cycle so the checker re-arms.
    - If `coll`=0, apply the move: rotate sets `curr_rotation`+1 mod 4; left sets `X_anchor`−1 mod 32; right sets `X_anchor`+1 mod 32; down sets `Y_anchor`+1 mod 64.
    - If `coll`=1 and `sel`=down: `lock_piece` pulses and all pending bits clear.
    - If `coll`=1 otherwise: no change.
    - Always return to IDLE.
- **`new_piece` in any state:** go to IDLE, drop `chk_enable`, load spawn values, no commit, no `lock_piece`.
- **Reset values:** state IDLE, `pending`=0, `rr`=0, `X_anchor`=`SPAWN_X`, `Y_anchor`=`SPAWN_Y`, `curr_rotation`=0, `chk_enable`=0, `lock_piece`=0, `busy`=0, `render_gnt`=0, `ram_addr`=0.
- **Reset mid-operation:** everything returns to reset values immediately. No partial move is ever committed.

## Timing
- **Registered vs combinational outputs.**
  - `chk_enable`, anchors, `curr_rotation`, `lock_piece` and `busy` are registered.
  - `ram_addr` and `render_gnt` are combinational from state, `sel` and `render_req`.
- **Service sequence.** Request pulse at edge E sets `pending` at E. With IDLE and no `render_req`:
  - E+1: state=CHECK, `chk_enable` high.
  - Edge after `chk_complete`: state=COMMIT, `chk_enable` low.
  - Next edge: anchors updated, `lock_piece` pulse, state=IDLE.
  - Minimum service time is 3 edges after the pending bit sets, plus checker latency.
- Only one move is ever in flight. Back-to-back requests are separated by at least one IDLE cycle.
- `render_req` held high in IDLE stalls checks indefinitely. The render engine must drop it between frames.

## Test plan
- **Basic move.** Reset, `req_left` pulse; checker model completes after 4 cycles with `collides`=0 → `X_anchor` 4→3, exactly one `chk_enable[1]` pulse, `busy` low 1 cycle after commit.
- **Gravity lock.** `req_down` with `collides`=1 → `Y_anchor` unchanged, `lock_piece` high exactly one cycle, `pending` cleared.
- **All four requests on the same edge.** Service order is rotate, left, right, down. Final `X_anchor`=4, `Y_anchor`=1, `curr_rotation`=1.
- **Render priority.** `render_req` high with rotate pending → `render_gnt`=1 and `ram_addr`=`render_addr`; the check starts the cycle after `render_req` falls.
- **Timeout.** `chk_complete` is never asserted → COMMIT after 7 CHECK cycles with `coll`=1, no anchor change, `chk_enable` returns to 0.
- **Abort and reset.**
  - `new_piece` mid-CHECK → immediate IDLE, X=4, Y=0, rotation 0, no commit.
  - `resetn` low mid-CHECK → all outputs at reset values asynchronously.
